// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for the 16x8 register unit: single read/write plus bulk
// fill/dump, sampling read data after a programmable settle window.
module regfile_access_ctrl #(
    parameter int REG_COUNT     = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [3:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [3:0]            rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rf_load,
    output logic [3:0]            rf_addr,
    output logic [DATA_WIDTH-1:0] rf_data_in,
    input  logic [DATA_WIDTH-1:0] rf_data_out,
    output logic                  busy
);
    localparam logic [3:0] LAST_IDX = 4'(REG_COUNT - 1);
    localparam logic [3:0] SETTLE   = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_FILL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_e;

    state_e                state_q;
    op_e                   op_q;
    logic [3:0]            idx_q;
    logic [3:0]            cnt_q;
    logic                  cmd_ready_q;
    logic                  rsp_valid_q;
    logic [3:0]            rsp_addr_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_last_q;
    logic                  rf_load_q;
    logic [3:0]            rf_addr_q;
    logic [DATA_WIDTH-1:0] rf_data_in_q;

    logic       accept;
    logic [3:0] idx_d;
    logic [3:0] start_idx_d;

    assign accept      = cmd_valid && cmd_ready_q;
    assign idx_d       = idx_q + 4'd1;
    // Bulk ops (op[1] set) always start at slot 0.
    assign start_idx_d = cmd_op[1] ? 4'd0 : cmd_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            idx_q        <= 4'd0;
            cnt_q        <= 4'd0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_addr_q   <= 4'd0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
            rf_load_q    <= 1'b0;
            rf_addr_q    <= 4'd0;
            rf_data_in_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Ready only rises after a full cycle spent idle.
                    cmd_ready_q <= !accept;
                    if (accept) begin
                        op_q      <= op_e'(cmd_op);
                        idx_q     <= start_idx_d;
                        rf_addr_q <= start_idx_d;
                        if (cmd_op[0]) begin
                            state_q      <= WRITE;
                            rf_load_q    <= 1'b1;
                            rf_data_in_q <= cmd_data;
                        end else begin
                            state_q <= READ_WAIT;
                            cnt_q   <= SETTLE;
                        end
                    end
                end
                WRITE: begin
                    if (op_q == OP_FILL && idx_q != LAST_IDX) begin
                        idx_q     <= idx_d;
                        rf_addr_q <= idx_d;
                    end else begin
                        rf_load_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                READ_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rf_data_out;
                        rsp_addr_q  <= idx_q;
                        rsp_last_q  <= (op_q == OP_READ) || (idx_q == LAST_IDX);
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (op_q == OP_DUMP && idx_q != LAST_IDX) begin
                            idx_q     <= idx_d;
                            rf_addr_q <= idx_d;
                            cnt_q     <= SETTLE;
                            state_q   <= READ_WAIT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_last   = rsp_last_q;
    assign rf_load    = rf_load_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data_in = rf_data_in_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural 16x8 register unit,
// plus SETTLE_CYCLES=1 and =15 instances for latency checks.
module tb_regfile_access_ctrl;
    localparam int SETTLE = 2;
    localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_DUMP = 2'b10, OP_FILL = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_addr = 4'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_last;
    logic [3:0] rsp_addr, rf_addr;
    logic [7:0] rsp_data, rf_data_in, rf_data_out;
    logic       rf_load, busy;

    always #5 clock = ~clock;

    regfile_access_ctrl #(.REG_COUNT(16), .DATA_WIDTH(8), .SETTLE_CYCLES(SETTLE)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .rf_load(rf_load), .rf_addr(rf_addr),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out), .busy(busy));

    logic [7:0] mem [16];
    always @(posedge clock) if (rf_load) mem[rf_addr] <= rf_data_in;
    assign rf_data_out = mem[rf_addr];

    // Latency instances share one command bus and always accept responses.
    logic       x_valid = 1'b0, x_rdy = 1'b1;
    logic [1:0] x_op = 2'b00;
    logic [3:0] x_addr = 4'd0;
    logic [7:0] x_data = 8'd0;
    logic       x1_ready, x1_rv, x1_last, x1_load, x1_busy;
    logic       x15_ready, x15_rv, x15_last, x15_load, x15_busy;
    logic [3:0] x1_raddr, x1_fa, x15_raddr, x15_fa;
    logic [7:0] x1_rdata, x1_fdi, x1_fdo, x15_rdata, x15_fdi, x15_fdo;
    logic [7:0] mem1 [16];
    logic [7:0] mem15 [16];

    regfile_access_ctrl #(.REG_COUNT(16), .DATA_WIDTH(8), .SETTLE_CYCLES(1)) dut_s1 (
        .clock(clock), .reset(reset), .cmd_valid(x_valid), .cmd_ready(x1_ready),
        .cmd_op(x_op), .cmd_addr(x_addr), .cmd_data(x_data),
        .rsp_valid(x1_rv), .rsp_ready(x_rdy), .rsp_addr(x1_raddr),
        .rsp_data(x1_rdata), .rsp_last(x1_last), .rf_load(x1_load), .rf_addr(x1_fa),
        .rf_data_in(x1_fdi), .rf_data_out(x1_fdo), .busy(x1_busy));
    regfile_access_ctrl #(.REG_COUNT(16), .DATA_WIDTH(8), .SETTLE_CYCLES(15)) dut_s15 (
        .clock(clock), .reset(reset), .cmd_valid(x_valid), .cmd_ready(x15_ready),
        .cmd_op(x_op), .cmd_addr(x_addr), .cmd_data(x_data),
        .rsp_valid(x15_rv), .rsp_ready(x_rdy), .rsp_addr(x15_raddr),
        .rsp_data(x15_rdata), .rsp_last(x15_last), .rf_load(x15_load), .rf_addr(x15_fa),
        .rf_data_in(x15_fdi), .rf_data_out(x15_fdo), .busy(x15_busy));

    always @(posedge clock) if (x1_load) mem1[x1_fa] <= x1_fdi;
    always @(posedge clock) if (x15_load) mem15[x15_fa] <= x15_fdi;
    assign x1_fdo  = mem1[x1_fa];
    assign x15_fdo = mem15[x15_fa];

    typedef struct packed {logic [3:0] a; logic [7:0] d; logic l;} rsp_t;
    typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
    rsp_t rq[$];
    wr_t  wq[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int acc_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Monitor: pops expected responses/writes and checks hold-stability under back-pressure.
    logic       stall = 1'b0;
    logic [3:0] s_a;
    logic [7:0] s_d;
    logic       s_l;
    rsp_t       er;
    wr_t        ew;
    always @(negedge clock) begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", int'(rsp_valid), 1);
                chk("hold_addr", int'(rsp_addr), int'(s_a));
                chk("hold_data", int'(rsp_data), int'(s_d));
                chk("hold_last", int'(rsp_last), int'(s_l));
            end
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_rsp: addr %0d data 0x%0h, expected none", rsp_addr, rsp_data);
                end else begin
                    er = rq.pop_front();
                    chk("rsp_addr", int'(rsp_addr), int'(er.a));
                    chk("rsp_data", int'(rsp_data), int'(er.d));
                    chk("rsp_last", int'(rsp_last), int'(er.l));
                end
            end
            stall = rsp_valid && !rsp_ready;
            s_a = rsp_addr;
            s_d = rsp_data;
            s_l = rsp_last;
            if (rf_load) begin
                if (wq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_load: addr %0d data 0x%0h, expected none", rf_addr, rf_data_in);
                end else begin
                    ew = wq.pop_front();
                    chk("load_addr", int'(rf_addr), int'(ew.a));
                    chk("load_data", int'(rf_data_in), int'(ew.d));
                end
            end
        end
    end

    // All main-process tasks are entered and left 1 time unit after a rising edge.
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
        logic r;
        int n = 0;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        forever begin
            r = cmd_ready;
            @(posedge clock); #1;
            n++;
            if (r) break;
            if (n > 300) begin timeout("send_accept"); break; end
        end
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        int n = 0;
        while (!cmd_ready && n < 300) begin @(posedge clock); #1; n++; end
        if (!cmd_ready) timeout("wait_ready");
        lat = cyc - acc_cyc;
    endtask

    task automatic drain();
        int n = 0;
        while (!(rq.size() == 0 && wq.size() == 0 && cmd_ready) && n < 800) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 800) timeout("drain");
    endtask

    task automatic x_send(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
        logic r;
        int n = 0;
        x_op = op; x_addr = a; x_data = d; x_valid = 1'b1;
        forever begin
            r = x1_ready && x15_ready;
            @(posedge clock); #1;
            n++;
            if (r) break;
            if (n > 300) begin timeout("x_send_accept"); break; end
        end
        acc_cyc = cyc;
        x_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, lat1, lat15;
        logic [7:0] d1, d15;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rf_load", int'(rf_load), 0);
        chk("rst_rf_addr", int'(rf_addr), 0);
        chk("rst_rf_data_in", int'(rf_data_in), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_addr", int'(rsp_addr), 0);
        chk("rst_rsp_last", int'(rsp_last), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_ready", int'(cmd_ready), 1);

        // Single write then read of slot 3
        wq.push_back({4'd3, 8'hA5});
        send(OP_WR, 4'd3, 8'hA5);
        chk("write_busy", int'(busy), 1);
        wait_ready(lat);
        chk("write_ready_lat", lat, 2);
        rq.push_back({4'd3, 8'hA5, 1'b1});
        send(OP_RD, 4'd3, 8'h00);
        chk("read_rf_addr", int'(rf_addr), 3);
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clock); #1; n++; end
        chk("read_latency", cyc - acc_cyc, SETTLE);
        drain();

        // Fill 0x3C then dump with rsp_ready held high
        for (int k = 0; k < 16; k++) wq.push_back({4'(k), 8'h3C});
        send(OP_FILL, 4'd9, 8'h3C);
        wait_ready(lat);
        chk("fill_ready_lat", lat, 17);
        for (int k = 0; k < 16; k++) rq.push_back({4'(k), 8'h3C, 1'(k == 15)});
        send(OP_DUMP, 4'd5, 8'hFF);
        drain();

        // Per-slot pattern k*0x11, dumped under random back-pressure
        for (int k = 0; k < 16; k++) begin
            wq.push_back({4'(k), 8'(k * 17)});
            send(OP_WR, 4'(k), 8'(k * 17));
        end
        drain();
        for (int k = 0; k < 16; k++) rq.push_back({4'(k), 8'(k * 17), 1'(k == 15)});
        send(OP_DUMP, 4'd0, 8'd0);
        n = 0;
        while (rq.size() > 0 && n < 1000) begin
            rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            n++;
        end
        rsp_ready = 1'b1;
        drain();

        // Read held off by rsp_ready=0 while a write waits on the command port
        rsp_ready = 1'b0;
        rq.push_back({4'd7, 8'h77, 1'b1});
        send(OP_RD, 4'd7, 8'h00);
        cmd_op = OP_WR; cmd_addr = 4'd7; cmd_data = 8'hE1; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("stall_cmd_ready", int'(cmd_ready), 0);
            chk("stall_rf_load", int'(rf_load), 0);
        end
        chk("stall_rsp_valid", int'(rsp_valid), 1);
        wq.push_back({4'd7, 8'hE1});
        rsp_ready = 1'b1;
        send(OP_WR, 4'd7, 8'hE1);
        chk("write_after_rsp", rq.size(), 0);
        drain();
        rq.push_back({4'd7, 8'hE1, 1'b1});
        send(OP_RD, 4'd7, 8'h00);
        drain();

        // Reset while slot 6 of a dump is being presented
        for (int k = 0; k < 6; k++) rq.push_back({4'(k), 8'(k * 17), 1'b0});
        send(OP_DUMP, 4'd0, 8'd0);
        n = 0;
        while (!(rsp_valid && rsp_addr == 4'd6) && n < 200) begin @(posedge clock); #1; n++; end
        if (n >= 200) timeout("dump_slot6");
        rsp_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rf_load", int'(rf_load), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        chk("abort_ready_back", int'(cmd_ready), 1);
        repeat (60) @(posedge clock);
        #1;
        chk("abort_no_more_rsp", rq.size(), 0);
        chk("abort_idle", int'(busy), 0);

        // SETTLE_CYCLES=1 and =15 latency
        x_send(OP_WR, 4'd5, 8'h96);
        x_send(OP_RD, 4'd5, 8'h00);
        lat1 = -1; lat15 = -1; d1 = 8'h00; d15 = 8'h00;
        for (int i = 0; i < 25; i++) begin
            if (x1_rv && lat1 < 0) begin lat1 = cyc - acc_cyc; d1 = x1_rdata; end
            if (x15_rv && lat15 < 0) begin lat15 = cyc - acc_cyc; d15 = x15_rdata; end
            @(posedge clock); #1;
        end
        chk("settle1_latency", lat1, 1);
        chk("settle1_data", int'(d1), 8'h96);
        chk("settle15_latency", lat15, 15);
        chk("settle15_data", int'(d15), 8'h96);

        drain();
        chk("end_rsp_queue", rq.size(), 0);
        chk("end_wr_queue", wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Command-driven initiator for the 16×8 register unit. It accepts single read/write commands and two bulk commands, fill and dump, over a valid/ready command port. It drives the register unit's load/addr/data_in pins and samples its data_out after a programmable settle window. Read data is returned on a valid/ready response port. It sits between the datapath sequencer and the register unit and is the only block allowed to drive the register unit's load, addr and data_in.

## Interface
- REG_COUNT, 16: number of register slots addressed; fixed at 16 (4-bit address).
- DATA_WIDTH, 8: register data width.
- SETTLE_CYCLES, 2: cycles rf_addr is held before rf_data_out is sampled; legal range 1..15.
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_op  input  2  00 read, 01 write, 10 dump (read all 16), 11 fill (write cmd_data to all 16).
- cmd_addr  input  4  target slot for read/write; ignored for dump/fill.
- cmd_data  input  8  write/fill data; ignored for read/dump.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer accepts response.
- rsp_addr  output  4  slot the response data came from.
- rsp_data  output  8  sampled register value.
- rsp_last  output  1  final response of a command (always 1 for read; 1 only at slot 15 for dump).
- rf_load  output  1  to register unit load.
- rf_addr  output  4  to register unit addr.
- rf_data_in  output  8  to register unit data_in.
- rf_data_out  input  8  from register unit data_out.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, WRITE, READ_WAIT, RESP.
- IDLE: cmd_ready=1. A command is accepted on a rising edge with cmd_valid&&cmd_ready. The edge latches op, addr (idx) and data. Bulk ops set idx=0.
  - write/fill → WRITE.
  - read/dump → READ_WAIT with wait counter = SETTLE_CYCLES.
- WRITE: rf_load=1, rf_addr=idx, rf_data_in=latched data, for exactly one cycle per slot.
  - Fill with idx<15: idx+1, stay in WRITE.
  - Otherwise → IDLE.
  - Writes and fill produce no response.
- READ_WAIT: rf_load=0, rf_addr=idx, counter decrements each cycle. On the cycle the counter reaches 1, rf_data_out is captured into rsp_data, idx into rsp_addr, and the state moves to RESP.
- RESP: rsp_valid=1; rsp_data/rsp_addr/rsp_last are held stable until rsp_ready.
  - On handshake, dump with idx<15: idx+1, counter reload, → READ_WAIT.
  - On handshake, otherwise → IDLE.
- rsp_last = 1 for a read, or for a dump when idx==15.
- Outside WRITE: rf_load=0. rf_addr holds the last idx, and rf_data_in holds the last data.
- idx is 4 bits and never wraps past 15 inside a command. The bulk loop terminates on idx==15.
- Unknown conditions do not exist: all four op codes are defined.

## Timing
- Reset (synchronous): state=IDLE, idx=0, counter=0.
  - Outputs: rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, rf_load=0, rf_addr=0, rf_data_in=0, busy=0.
  - cmd_ready=0 while reset is high; cmd_ready=1 the first cycle after reset falls.
- Reset mid-operation aborts the command and returns to IDLE next edge. A pending response is dropped and no further rf_load is issued.
- Write: accepted at edge N. rf_load high in cycle N..N+1. cmd_ready high again from edge N+2.
- Read: accepted at edge N. rf_addr valid from N. Sample at edge N+SETTLE_CYCLES. rsp_valid high from that edge.
- Fill: rf_load high for 16 consecutive cycles with rf_addr 0..15. cmd_ready returns 17 cycles after acceptance.
- Dump: 16 responses in slot order 0..15. Each is preceded by SETTLE_CYCLES of READ_WAIT. Back-pressure on rsp_ready stalls the sequence without losing data.
- A read issued the cycle after a write completes observes the written value (SETTLE_CYCLES≥1 covers the register unit's registered output).
- cmd_valid while busy is ignored (cmd_ready=0). Commands are never queued.

## Test plan
- Reset, then write addr 3 data 0xA5, then read addr 3 → rf_load one cycle with rf_addr=3, rf_data_in=0xA5. Response rsp_addr=3, rsp_data=0xA5, rsp_last=1, SETTLE_CYCLES after acceptance.
- Fill 0x3C, then dump with rsp_ready=1 → 16 rf_load pulses, then 16 responses addr 0..15 all 0x3C. rsp_last only on addr 15.
- Write slot k=k*0x11 for k=0..15, dump with rsp_ready toggled randomly → responses in order 0..15 with data k*0x11. Each response is held stable while rsp_ready=0.
- Read addr 7 with rsp_ready=0 for 10 cycles while cmd_valid stays high with a write → cmd_ready=0 throughout, no rf_load. The write is accepted only after the response handshake.
- Assert reset during dump at slot 6 → next cycle rsp_valid=0, busy=0, rf_load=0. cmd_ready=1 after reset falls, and no responses from slots 7..15 appear.
- SETTLE_CYCLES=1 and =15 builds: read latency is exactly 1 and 15 cycles respectively, with data matching the prior write.
